// File: rtl/seg_scan_pkg.sv
// Shared constants for the 7-segment scan driver: state encoding, blank/DP codes
// and active-low hex digit patterns (also used by the decoder and testbench).
package seg_scan_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int         DP_BIT    = 7;

    typedef enum logic {
        GUARD   = 1'b0,
        DISPLAY = 1'b1
    } scan_state_e;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    function automatic logic [7:0] seg_digit(input logic [7:0] pattern, input logic blank);
        seg_digit = blank ? SEG_BLANK : pattern;
    endfunction

endpackage

// File: rtl/scan_tick_div.sv
// Dwell/guard prescaler: counts 0..reload and flags the terminal count, then
// restarts at 0 so the next phase can use a different reload value.
module scan_tick_div #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] reload,
    output logic          tc
);

    logic [CW-1:0] cnt_r;

    assign tc = (cnt_r == reload);

    // Free-running phase counter, cleared on terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (tc) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with guard time and a
// tear-free load/ack double buffer. Optional DP blink via SEG_DP_BLINK_EN.
module seg_scan_driver
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYC    = 8,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*NUM_DIGITS-1:0] seg_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    load_ack,
    output logic                    frame_done
);

    localparam int CW = $clog2(SCAN_DIV + GUARD_CYC + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] DWELL_RELOAD = CW'(SCAN_DIV - 1);
    // A zero-length guard still needs one cycle after reset before the first digit
    localparam logic [CW-1:0] GUARD_RELOAD = CW'((GUARD_CYC == 0) ? 0 : GUARD_CYC - 1);
    localparam logic [IW-1:0] LAST_IDX     = IW'(NUM_DIGITS - 1);

    scan_state_e               state_r, state_nxt_s;
    logic [IW-1:0]             idx_r, idx_nxt_s;
    logic [8*NUM_DIGITS-1:0]   buf_r, buf_nxt_s, pend_r;
    logic                      pend_valid_r;
    logic                      tc_s, boundary_s, commit_s;
    logic [7:0]                seg_nxt_s;
    logic [NUM_DIGITS-1:0]     dig_nxt_s;
    logic [CW-1:0]             reload_s;

    assign reload_s = (state_r == DISPLAY) ? DWELL_RELOAD : GUARD_RELOAD;

    scan_tick_div #(.CW(CW)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .reload (reload_s),
        .tc     (tc_s)
    );

`ifdef SEG_DP_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(BLINK_FRAMES - 1);
    logic [FW-1:0] frame_cnt_r;
    logic          blink_phase_r;

    // Frame counter toggling the DP blink phase every BLINK_FRAMES frames
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r   <= {FW{1'b0}};
            blink_phase_r <= 1'b0;
        end else if (boundary_s) begin
            if (frame_cnt_r == LAST_FRAME) begin
                frame_cnt_r   <= {FW{1'b0}};
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frame_cnt_r   <= frame_cnt_r + 1'b1;
                blink_phase_r <= blink_phase_r;
            end
        end else begin
            frame_cnt_r   <= frame_cnt_r;
            blink_phase_r <= blink_phase_r;
        end
    end
`endif

    // Next scan position, frame boundary/commit, and next-cycle output values
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        boundary_s  = 1'b0;
        case (state_r)
            GUARD: begin
                if (tc_s) state_nxt_s = DISPLAY;
                else      state_nxt_s = GUARD;
            end
            DISPLAY: begin
                if (tc_s) begin
                    idx_nxt_s   = (idx_r == LAST_IDX) ? {IW{1'b0}} : idx_r + 1'b1;
                    boundary_s  = (idx_r == LAST_IDX);
                    state_nxt_s = (GUARD_CYC == 0) ? DISPLAY : GUARD;
                end else begin
                    state_nxt_s = DISPLAY;
                end
            end
            default: state_nxt_s = GUARD;
        endcase

        commit_s  = boundary_s & pend_valid_r;
        buf_nxt_s = commit_s ? pend_r : buf_r;

        seg_nxt_s = SEG_BLANK;
        dig_nxt_s = {NUM_DIGITS{1'b1}};
        if (state_nxt_s == DISPLAY) begin
            seg_nxt_s            = seg_digit(buf_nxt_s[{idx_nxt_s, 3'b000} +: 8], blank_mask[idx_nxt_s]);
            dig_nxt_s[idx_nxt_s] = 1'b0;
`ifdef SEG_DP_BLINK_EN
            if (blink_phase_r && !blank_mask[idx_nxt_s] &&
                (idx_nxt_s == IW'(1) || idx_nxt_s == IW'(3))) begin
                seg_nxt_s[DP_BIT] = 1'b0;
            end else begin
                seg_nxt_s[DP_BIT] = seg_nxt_s[DP_BIT];
            end
`endif
        end else begin
            seg_nxt_s = SEG_BLANK;
        end
    end

    // Scan state, display/pending buffers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= GUARD;
            idx_r        <= {IW{1'b0}};
            buf_r        <= {NUM_DIGITS{SEG_BLANK}};
            pend_r       <= {NUM_DIGITS{SEG_BLANK}};
            pend_valid_r <= 1'b0;
            seg_out      <= SEG_BLANK;
            dig_sel      <= {NUM_DIGITS{1'b1}};
            load_ack     <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            buf_r      <= buf_nxt_s;
            seg_out    <= seg_nxt_s;
            dig_sel    <= dig_nxt_s;
            load_ack   <= commit_s;
            frame_done <= boundary_s;
            // A load on the commit cycle refills pending after the old data moved out
            if (load) begin
                pend_r       <= seg_in;
                pend_valid_r <= 1'b1;
            end else if (commit_s) begin
                pend_r       <= pend_r;
                pend_valid_r <= 1'b0;
            end else begin
                pend_r       <= pend_r;
                pend_valid_r <= pend_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (4 digits, dwell 4, guard 2) against a
// timeline model: frame position is derived from cycles since reset release.
module tb_seg_scan_driver;
    import seg_scan_pkg::*;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int GC = 2;
    localparam int SL = SD + GC;
    localparam int FR = ND * SL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [31:0] seg_in = 32'h0;
    logic [3:0]  blank_mask = 4'h0;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        load_ack;
    logic        frame_done;

    int          checks = 0;
    int          failures = 0;
    int          k = 0;
    int          n_ack = 0;
    int          ack_base;
    logic [31:0] m_disp = 32'hFFFF_FFFF;
    logic [31:0] m_pend = 32'hFFFF_FFFF;
    logic        m_pv = 1'b0;
    logic        m_ack = 1'b0;

    seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD_CYC(GC), .BLINK_FRAMES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .load       (load),
        .blank_mask (blank_mask),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .load_ack   (load_ack),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h k=%0d", tag, obs, exp, k);
        end
    endtask

    // One clock: drive inputs, advance the model to the edge, compare after it
    task automatic step(input logic ld, input logic [31:0] d, input logic [3:0] bm);
        int p;
        int dg;
        logic [7:0] es;
        logic [3:0] ed;
        logic       efd;
        load = ld;
        seg_in = d;
        blank_mask = bm;
        @(posedge clk);
        k++;
        m_ack = 1'b0;
        efd = (k >= FR) && (((k - GC) % FR) == (FR - GC));
        if (efd && m_pv) begin
            m_disp = m_pend;
            m_pv = 1'b0;
            m_ack = 1'b1;
        end
        if (ld) begin
            m_pend = d;
            m_pv = 1'b1;
        end
        es = 8'hFF;
        ed = 4'hF;
        if (k >= GC) begin
            p = (k - GC) % FR;
            dg = p / SL;
            if ((p % SL) < SD) begin
                ed = ~(4'b0001 << dg);
                es = bm[dg] ? 8'hFF : m_disp[dg*8 +: 8];
            end
        end
        #1;
        if (load_ack === 1'b1) n_ack++;
        chk("seg_out", 32'(seg_out), 32'(es));
        chk("dig_sel", 32'(dig_sel), 32'(ed));
        chk("frame_done", 32'(frame_done), 32'(efd));
        chk("load_ack", 32'(load_ack), 32'(m_ack));
    endtask

    // Idle until the next edge lands on frame position tp (bounded)
    task automatic to_pos(input int tp);
        int n;
        n = 0;
        while ((((k + 1 - GC) % FR) != tp) && (n < FR)) begin
            step(1'b0, 32'h0, 4'h0);
            n++;
        end
        chk("to_pos_reached", 32'(((k + 1 - GC) % FR)), 32'(tp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 4'h0);
    endtask

    initial begin
        // Reset held: everything off and idle
        repeat (5) begin
            @(negedge clk);
            chk("rst_seg", 32'(seg_out), 32'h0000_00FF);
            chk("rst_dig", 32'(dig_sel), 32'h0000_000F);
            chk("rst_ack", 32'(load_ack), 32'h0);
            chk("rst_fd", 32'(frame_done), 32'h0);
        end
        rst_n = 1'b1;
        idle(8);

        // Single load committed at the next boundary
        step(1'b1, {SEG_3, SEG_2, SEG_1, SEG_0}, 4'h0);
        idle(2 * FR);

        // Two loads in one frame: one ack, latest data wins
        to_pos(1);
        ack_base = n_ack;
        step(1'b1, 32'hB0A4_F9C0, 4'h0);
        idle(3);
        step(1'b1, 32'h99B0_A4F9, 4'h0);
        idle(FR);
        chk("double_load_acks", 32'(n_ack - ack_base), 32'd1);

        // Load on the boundary edge: old pending commits, new one a frame later
        to_pos(3);
        ack_base = n_ack;
        step(1'b1, {SEG_5, SEG_6, SEG_7, SEG_8}, 4'h0);
        to_pos(FR - GC);
        step(1'b1, {SEG_A, SEG_B, SEG_C, SEG_D}, 4'h0);
        idle(FR + 2);
        chk("boundary_load_acks", 32'(n_ack - ack_base), 32'd2);

        // Blanking digit 1 for two frames
        for (int i = 0; i < 2 * FR; i++) step(1'b0, 32'h0, 4'b0010);

        // Randomized loads and blanking
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) == 0), $urandom,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0);
        end

        // Asynchronous reset during digit 2 with pending data outstanding
        to_pos(2 * SL);
        step(1'b1, 32'h1234_5678, 4'h0);
        step(1'b0, 32'h0, 4'h0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_seg", 32'(seg_out), 32'h0000_00FF);
        chk("async_rst_dig", 32'(dig_sel), 32'h0000_000F);
        chk("async_rst_ack", 32'(load_ack), 32'h0);
        k = 0;
        m_disp = 32'hFFFF_FFFF;
        m_pv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ack_base = n_ack;
        idle(2 * FR + 4);
        chk("post_rst_no_ack", 32'(n_ack - ack_base), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
